// File: rtl/sram_fi.sv
// sram_fi: single-port synchronous SRAM model with a run-time programmable
// fault-injection table.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   addr_in         access address
//   dat_in          write data
//   w_en, r_en      write / read strobes, one access per cycle, no backpressure
//   read_d          read data (holds its last value between reads)
//   read_vld        read data strobe
//   fi_wr, fi_clr   load entry fi_idx / disable every entry (clear wins)
//   fi_idx          entry index; indices >= NUM_FAULTS are ignored
//   fi_en, fi_type  entry enable and type (0 SA0, 1 SA1, 2 TF-up, 3 CF-inv)
//   fi_addr, fi_bit victim word and bit
//   fi_aggr_addr,
//   fi_aggr_bit     aggressor word and bit (CF-inv only)
//
// Handshake: there is no ready. Every cycle with r_en=1 is a read that is
// answered exactly once, in order, by a single-cycle read_vld pulse 1 cycle
// (OUT_REG=0) or 2 cycles (OUT_REG=1) later, with read_d valid while
// read_vld=1. Reads issued back to back give back-to-back pulses.
//
// The array itself has no reset so its contents survive rst_n. Fault-table
// updates are registered, so an access in the same cycle sees the old table.

module sram_fi #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 8,
  parameter int OUT_REG    = 0,
  parameter int NUM_FAULTS = 4,
  parameter int FI_W       = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  parameter int BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] dat_in,
  input  logic              w_en,
  input  logic              r_en,
  output logic [DATA_W-1:0] read_d,
  output logic              read_vld,
  input  logic              fi_wr,
  input  logic              fi_clr,
  input  logic [FI_W-1:0]   fi_idx,
  input  logic              fi_en,
  input  logic [1:0]        fi_type,
  input  logic [ADDR_W-1:0] fi_addr,
  input  logic [BIT_W-1:0]  fi_bit,
  input  logic [ADDR_W-1:0] fi_aggr_addr,
  input  logic [BIT_W-1:0]  fi_aggr_bit
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    FT_SA0    = 2'd0,
    FT_SA1    = 2'd1,
    FT_TF_UP  = 2'd2,
    FT_CF_INV = 2'd3
  } fault_type_e;

  typedef struct packed {
    logic              en;
    fault_type_e       ftype;
    logic [ADDR_W-1:0] vaddr;
    logic [BIT_W-1:0]  vbit;
    logic [ADDR_W-1:0] aaddr;
    logic [BIT_W-1:0]  abit;
  } fault_entry_t;

  logic [DATA_W-1:0] ram [DEPTH];
  fault_entry_t      ft  [NUM_FAULTS];

  // ---------------------------------------------------------------------
  // Fault table
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FAULTS; i++) ft[i] <= '0;
    end else if (fi_clr) begin
      for (int i = 0; i < NUM_FAULTS; i++) ft[i].en <= 1'b0;
    end else if (fi_wr) begin
      // Compare against every slot so an out-of-range index simply matches none.
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (fi_idx == FI_W'(i)) begin
          ft[i].en    <= fi_en;
          ft[i].ftype <= fault_type_e'(fi_type);
          ft[i].vaddr <= fi_addr;
          ft[i].vbit  <= fi_bit;
          ft[i].aaddr <= fi_aggr_addr;
          ft[i].abit  <= fi_aggr_bit;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-entry bit masks; an out-of-range bit index yields an empty mask so
  // the entry can never match.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] vmask [NUM_FAULTS];
  logic [DATA_W-1:0] amask [NUM_FAULTS];

  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      vmask[i] = '0;
      amask[i] = '0;
      if (int'(ft[i].vbit) < DATA_W) vmask[i] = DATA_W'(1) << ft[i].vbit;
      if (int'(ft[i].abit) < DATA_W) amask[i] = DATA_W'(1) << ft[i].abit;
    end
  end

  // ---------------------------------------------------------------------
  // Write path: stuck-at / transition masking on the addressed word
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] masked_word;

  always_comb begin
    old_word    = ram[addr_in];
    masked_word = dat_in;
    // Ascending order: a later entry sees the candidate left by earlier ones.
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (ft[i].en && ft[i].vaddr == addr_in) begin
        case (ft[i].ftype)
          FT_SA0:   masked_word = masked_word & ~vmask[i];
          FT_SA1:   masked_word = masked_word | vmask[i];
          FT_TF_UP: begin
            if (((old_word & vmask[i]) == '0) && ((masked_word & vmask[i]) != '0))
              masked_word = masked_word & ~vmask[i];
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Coupling faults: an aggressor bit that changes value on this write
  // inverts its victim bit.
  // ---------------------------------------------------------------------
  logic [NUM_FAULTS-1:0] cf_hit;

  always_comb begin
    cf_hit = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      cf_hit[i] = w_en && ft[i].en && (ft[i].ftype == FT_CF_INV) &&
                  (ft[i].aaddr == addr_in) && (vmask[i] != '0) &&
                  (((masked_word ^ old_word) & amask[i]) != '0);
    end
  end

  // Complete post-write image of each victim word. Every entry sharing a
  // victim address computes the same word (all hits XORed in), so the
  // order of the array updates below does not matter.
  logic [DATA_W-1:0] victim_word [NUM_FAULTS];

  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      victim_word[i] = (ft[i].vaddr == addr_in) ? masked_word : ram[ft[i].vaddr];
      for (int j = 0; j < NUM_FAULTS; j++) begin
        if (cf_hit[j] && ft[j].vaddr == ft[i].vaddr)
          victim_word[i] = victim_word[i] ^ vmask[j];
      end
    end
  end

  // Word finally stored at addr_in, including a self-coupled inversion.
  logic [DATA_W-1:0] final_word;

  always_comb begin
    final_word = masked_word;
    for (int j = 0; j < NUM_FAULTS; j++) begin
      if (cf_hit[j] && ft[j].vaddr == addr_in) final_word = final_word ^ vmask[j];
    end
  end

  // Storage array: no reset, contents are retained.
  always_ff @(posedge clk) begin
    if (w_en) begin
      ram[addr_in] <= masked_word;
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (cf_hit[i]) ram[ft[i].vaddr] <= victim_word[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path: write-first, stuck-at faults forced on the way out so that
  // preloaded stuck cells still read stuck.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = w_en ? final_word : ram[addr_in];
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (ft[i].en && ft[i].vaddr == addr_in) begin
        if (ft[i].ftype == FT_SA0) rd_word = rd_word & ~vmask[i];
        if (ft[i].ftype == FT_SA1) rd_word = rd_word | vmask[i];
      end
    end
  end

  logic [DATA_W-1:0] s1_d;
  logic              s1_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_d   <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= r_en;
      if (r_en) s1_d <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s2_d;
      logic              s2_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_d   <= '0;
          s2_vld <= 1'b0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_d <= s1_d;
        end
      end

      assign read_d   = s2_d;
      assign read_vld = s2_vld;
    end else begin : g_no_out_reg
      assign read_d   = s1_d;
      assign read_vld = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_sram_fi.sv
// tb_sram_fi: drives the same access stream into an OUT_REG=0 and an
// OUT_REG=1 instance of sram_fi. Each read pushes its hand-computed data and
// the cycle its read_vld must appear on into per-instance queues; a monitor
// per instance pops and compares whenever read_vld is high.

module tb_sram_fi;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr_in;
  logic [3:0] dat_in;
  logic       w_en;
  logic       r_en;
  logic       fi_wr;
  logic       fi_clr;
  logic [1:0] fi_idx;
  logic       fi_en;
  logic [1:0] fi_type;
  logic [7:0] fi_addr;
  logic [1:0] fi_bit;
  logic [7:0] fi_aggr_addr;
  logic [1:0] fi_aggr_bit;

  logic [3:0] read_d0, read_d1;
  logic       read_vld0, read_vld1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] exp0_q[$];
  logic [3:0] exp1_q[$];
  int         cyc0_q[$];
  int         cyc1_q[$];

  sram_fi #(.DATA_W(4), .ADDR_W(8), .OUT_REG(0), .NUM_FAULTS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .dat_in(dat_in),
    .w_en(w_en), .r_en(r_en), .read_d(read_d0), .read_vld(read_vld0),
    .fi_wr(fi_wr), .fi_clr(fi_clr), .fi_idx(fi_idx), .fi_en(fi_en),
    .fi_type(fi_type), .fi_addr(fi_addr), .fi_bit(fi_bit),
    .fi_aggr_addr(fi_aggr_addr), .fi_aggr_bit(fi_aggr_bit)
  );

  sram_fi #(.DATA_W(4), .ADDR_W(8), .OUT_REG(1), .NUM_FAULTS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .dat_in(dat_in),
    .w_en(w_en), .r_en(r_en), .read_d(read_d1), .read_vld(read_vld1),
    .fi_wr(fi_wr), .fi_clr(fi_clr), .fi_idx(fi_idx), .fi_en(fi_en),
    .fi_type(fi_type), .fi_addr(fi_addr), .fi_bit(fi_bit),
    .fi_aggr_addr(fi_aggr_addr), .fi_aggr_bit(fi_aggr_bit)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitors ----------------
  always @(posedge clk) begin
    #1;
    if (read_vld0) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld0: read_vld=1 read_d=%h at cycle %0d, none expected", read_d0, cyc);
      end else begin
        logic [3:0] e;
        int         c;
        e = exp0_q.pop_front();
        c = cyc0_q.pop_front();
        if (read_d0 !== e || cyc != c) begin
          errors++;
          $display("FAIL read0: got %h at cycle %0d, expected %h at cycle %0d", read_d0, cyc, e, c);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (read_vld1) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld1: read_vld=1 read_d=%h at cycle %0d, none expected", read_d1, cyc);
      end else begin
        logic [3:0] e;
        int         c;
        e = exp1_q.pop_front();
        c = cyc1_q.pop_front();
        if (read_d1 !== e || cyc != c) begin
          errors++;
          $display("FAIL read1: got %h at cycle %0d, expected %h at cycle %0d", read_d1, cyc, e, c);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns on the next falling edge.
  task automatic access(input logic we, input logic re, input logic [7:0] a,
                        input logic [3:0] d, input logic [3:0] e);
    w_en    = we;
    r_en    = re;
    addr_in = a;
    dat_in  = d;
    if (re) begin
      exp0_q.push_back(e);
      cyc0_q.push_back(cyc + 1);
      exp1_q.push_back(e);
      cyc1_q.push_back(cyc + 2);
    end
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] d);
    access(1'b1, 1'b0, a, d, 4'h0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [3:0] e);
    access(1'b0, 1'b1, a, 4'h0, e);
  endtask

  task automatic fi_load(input int idx, input logic en, input logic [1:0] t,
                         input logic [7:0] a, input int b,
                         input logic [7:0] aa, input int ab);
    fi_idx       = 2'(idx);
    fi_en        = en;
    fi_type      = t;
    fi_addr      = a;
    fi_bit       = 2'(b);
    fi_aggr_addr = aa;
    fi_aggr_bit  = 2'(ab);
    fi_wr        = 1'b1;
    @(negedge clk);
    fi_wr = 1'b0;
  endtask

  task automatic fi_clear();
    fi_clr = 1'b1;
    @(negedge clk);
    fi_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    addr_in = '0; dat_in = '0; w_en = 1'b0; r_en = 1'b0;
    fi_wr = 1'b0; fi_clr = 1'b0; fi_idx = '0; fi_en = 1'b0; fi_type = '0;
    fi_addr = '0; fi_bit = '0; fi_aggr_addr = '0; fi_aggr_bit = '0;
    repeat (3) @(negedge clk);
    chk("reset_read_d0", read_d0, 4'h0);
    chk("reset_vld0", {3'b0, read_vld0}, 4'h0);
    chk("reset_read_d1", read_d1, 4'h0);
    chk("reset_vld1", {3'b0, read_vld1}, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic read/write
    wr(8'h10, 4'hA);
    rd(8'h10, 4'hA);
    wr(8'h11, 4'h5);
    rd(8'h11, 4'h5);

    // Stuck-at faults
    fi_load(0, 1'b1, 2'd0, 8'h20, 1, 8'h00, 0);   // SA0 @0x20 bit1
    wr(8'h20, 4'hF);
    rd(8'h20, 4'hD);
    fi_load(0, 1'b1, 2'd1, 8'h20, 3, 8'h00, 0);   // SA1 @0x20 bit3 replaces it
    wr(8'h20, 4'h0);
    rd(8'h20, 4'h8);
    wr(8'h20, 4'hF);
    rd(8'h20, 4'hF);
    fi_clear();
    wr(8'h20, 4'h0);
    rd(8'h20, 4'h0);

    // Clear has priority over a simultaneous load
    fi_idx = 2'd3; fi_en = 1'b1; fi_type = 2'd0; fi_addr = 8'h10; fi_bit = 2'd1;
    fi_wr = 1'b1; fi_clr = 1'b1;
    @(negedge clk);
    fi_wr = 1'b0; fi_clr = 1'b0;
    rd(8'h10, 4'hA);

    // Transition-up fault
    fi_load(1, 1'b1, 2'd2, 8'h30, 0, 8'h00, 0);
    wr(8'h30, 4'h0);
    wr(8'h30, 4'h1);
    rd(8'h30, 4'h0);
    wr(8'h30, 4'hF);
    rd(8'h30, 4'hE);
    fi_load(1, 1'b0, 2'd2, 8'h30, 0, 8'h00, 0);
    wr(8'h30, 4'h1);
    rd(8'h30, 4'h1);

    // Coupling faults: aggressor 0x40 bit3 -> victims 0x41 bit0 and 0x40 bit0
    wr(8'h40, 4'h0);
    fi_load(2, 1'b1, 2'd3, 8'h41, 0, 8'h40, 3);
    fi_load(3, 1'b1, 2'd3, 8'h40, 0, 8'h40, 3);
    wr(8'h41, 4'h0);
    wr(8'h40, 4'h8);
    rd(8'h41, 4'h1);
    rd(8'h40, 4'h9);
    wr(8'h40, 4'h8);
    rd(8'h41, 4'h1);
    rd(8'h40, 4'h8);
    wr(8'h40, 4'h0);
    rd(8'h41, 4'h0);
    rd(8'h40, 4'h1);
    // A second identical coupling on 0x41 bit0 cancels the first
    fi_load(1, 1'b1, 2'd3, 8'h41, 0, 8'h40, 3);
    wr(8'h40, 4'h8);
    rd(8'h41, 4'h0);
    rd(8'h40, 4'h9);
    fi_clear();

    // Simultaneous write and read: write-first
    access(1'b1, 1'b1, 8'h50, 4'h6, 4'h6);
    fi_load(0, 1'b1, 2'd0, 8'h50, 1, 8'h00, 0);   // SA0 @0x50 bit1 on read path
    rd(8'h50, 4'h4);
    repeat (3) @(negedge clk);

    // Reset asserted while a read is set up: nothing is returned
    r_en = 1'b1; addr_in = 8'h50;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_read_d0", read_d0, 4'h0);
    chk("async_rst_read_d1", read_d1, 4'h0);
    @(posedge clk);
    #1;
    chk("rst_vld0", {3'b0, read_vld0}, 4'h0);
    chk("rst_vld1", {3'b0, read_vld1}, 4'h0);
    r_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(8'h50, 4'h6);   // array retained, fault table emptied

    // Back-to-back reads
    rd(8'h10, 4'hA);
    rd(8'h11, 4'h5);
    rd(8'h50, 4'h6);

    repeat (6) @(negedge clk);
    chk("drain_q0", 4'(exp0_q.size()), 4'h0);
    chk("drain_q1", 4'(exp1_q.size()), 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
